// File: rtl/adder_acc_ctrl.sv
// -----------------------------------------------------------------------------
// adder / adder_acc_ctrl
//
// adder: combinational NUM-input signed adder tree. Wraps modulo 2^WIDTH.
//   data  in  NUM*WIDTH : operands, element k at [k*WIDTH +: WIDTH]
//   sum   out WIDTH     : sum of all elements
//
// adder_acc_ctrl: streams a LEN-element signed vector through one adder,
// NUM elements per beat, and accumulates the beat sums. The finished total
// is presented on a valid/ready output port.
//   clk        in  1         : rising-edge clock
//   rst        in  1         : synchronous active-high reset
//   flush      in  1         : synchronous abort of partial / pending result
//   in_valid   in  1         : in_data holds a beat
//   in_ready   out 1         : a beat is accepted this cycle
//   in_data    in  NUM*WIDTH : beat, element k at [k*WIDTH +: WIDTH]
//   out_valid  out 1         : out_data holds a completed vector sum
//   out_ready  in  1         : downstream accepts the result
//   out_data   out WIDTH     : accumulated vector sum
//   busy       out 1         : vector in progress or result pending
// -----------------------------------------------------------------------------

module adder #(
   parameter int NUM   = 2,
   parameter int WIDTH = 32
) (
   input  logic [NUM*WIDTH-1:0] data,
   output logic [WIDTH-1:0]     sum
);

   // Sum every element of the beat; carries out of WIDTH are discarded.
   always_comb begin
      sum = '0;
      for (int k = 0; k < NUM; k++) begin
         sum = sum + data[k*WIDTH +: WIDTH];
      end
   end

endmodule

module adder_acc_ctrl #(
   parameter int NUM   = 2,
   parameter int WIDTH = 32,
   parameter int LEN   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [NUM*WIDTH-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic                 busy
);

   localparam int BEATS = LEN / NUM;
   localparam int CW    = $clog2(BEATS) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);
   // A single-beat vector completes on its first accept.
   localparam state_t FIRST_NXT = (BEATS == 1) ? DONE : ACC;

   state_t            state_r;
   logic [WIDTH-1:0]  acc_r;
   logic [CW-1:0]     cnt_r;
   logic              out_valid_r;
   logic              in_ready_r;
   logic              busy_r;
   logic [WIDTH-1:0]  tsum_s;

   // Output flags {out_valid, in_ready, busy} that belong to a given state.
   // They are registered together with the state so no input reaches an
   // output combinationally.
   function automatic logic [2:0] flags_f(input state_t s);
      case (s)
         IDLE:    flags_f = 3'b010;
         ACC:     flags_f = 3'b011;
         DONE:    flags_f = 3'b101;
         default: flags_f = 3'b010;
      endcase
   endfunction

   adder #(
      .NUM   (NUM),
      .WIDTH (WIDTH)
   ) u_adder (
      .data (in_data),
      .sum  (tsum_s)
   );

   // Sequencing FSM: accumulate BEATS accepted beats, then hold the result
   // until the output handshake. rst beats flush beats normal operation.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         // flush behaves like reset: partial sum, pending result and the
         // beat presented this cycle are all discarded.
         state_r                              <= IDLE;
         acc_r                                <= '0;
         cnt_r                                <= '0;
         {out_valid_r, in_ready_r, busy_r}    <= flags_f(IDLE);
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  acc_r                             <= tsum_s;
                  cnt_r                             <= CW'(1);
                  state_r                           <= FIRST_NXT;
                  {out_valid_r, in_ready_r, busy_r} <= flags_f(FIRST_NXT);
               end else begin
                  state_r <= IDLE;
               end
            end
            ACC: begin
               if (in_valid) begin
                  acc_r <= acc_r + tsum_s;
                  cnt_r <= cnt_r + CW'(1);
                  if (cnt_r == LAST_CNT) begin
                     state_r                           <= DONE;
                     {out_valid_r, in_ready_r, busy_r} <= flags_f(DONE);
                  end else begin
                     state_r <= ACC;
                  end
               end else begin
                  // Input gap: everything holds.
                  state_r <= ACC;
               end
            end
            DONE: begin
               // in_ready is low here, so a beat offered alongside the
               // output handshake is left for the next cycle.
               if (out_ready) begin
                  state_r                           <= IDLE;
                  cnt_r                             <= '0;
                  {out_valid_r, in_ready_r, busy_r} <= flags_f(IDLE);
               end else begin
                  state_r <= DONE;
               end
            end
            default: begin
               state_r                           <= IDLE;
               acc_r                             <= '0;
               cnt_r                             <= '0;
               {out_valid_r, in_ready_r, busy_r} <= flags_f(IDLE);
            end
         endcase
      end
   end

   assign out_valid = out_valid_r;
   assign in_ready  = in_ready_r;
   assign busy      = busy_r;
   assign out_data  = acc_r;

endmodule

// File: tb/tb_adder_acc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adder_acc_ctrl: self-checking bench for adder_acc_ctrl.
// u0: NUM=2, WIDTH=32, LEN=8 (four beats per vector).
// u1: NUM=4, WIDTH=32, LEN=4 (one beat per vector).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------

module tb_adder_acc_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
   logic [63:0] in_data;
   logic [31:0] out_data;

   logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
   logic [127:0] b_in_data;
   logic [31:0]  b_out_data;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] sb[$];

   typedef struct {
      logic [255:0] el;
      logic [15:0]  pat;
      logic [31:0]  exp;
      string        nm;
   } vec_t;

   vec_t tbl[5];

   adder_acc_ctrl #(.NUM(2), .WIDTH(32), .LEN(8)) u0 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
   );

   adder_acc_ctrl #(.NUM(4), .WIDTH(32), .LEN(4)) u1 (
      .clk(clk), .rst(rst), .flush(b_flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .busy(b_busy)
   );

   function automatic logic [255:0] mk(input int a0, input int a1, input int a2, input int a3,
                                       input int a4, input int a5, input int a6, input int a7);
      return {a7, a6, a5, a4, a3, a2, a1, a0};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
      end
   endtask

   task automatic check_reset(input string nm);
      chk({nm, "_out_valid"}, {31'd0, out_valid}, 32'd0);
      chk({nm, "_out_data"},  out_data,           32'd0);
      chk({nm, "_busy"},      {31'd0, busy},      32'd0);
      chk({nm, "_in_ready"},  {31'd0, in_ready},  32'd1);
   endtask

   // Drive one four-beat vector following a valid pattern (bit i = cycle i),
   // then check the result appears on the very next sample.
   task automatic run_vec(input logic [255:0] el, input logic [15:0] pat,
                          input logic [31:0] exp, input string nm);
      int b   = 0;
      int cyc = 0;
      while (b < 4 && cyc < 16) begin
         in_valid = pat[cyc];
         in_data  = el[b*64 +: 64];
         @(negedge clk);
         if (pat[cyc]) b++;
         cyc++;
         if (b < 4) chk({nm, "_busy_mid"}, {31'd0, busy}, (b > 0) ? 32'd1 : 32'd0);
      end
      in_valid = 1'b0;
      chk({nm, "_beats"}, 32'(b), 32'd4);
      sb.push_back(exp);
      if (out_valid) begin
         chk({nm, "_sum"}, out_data, sb.pop_front());
      end else begin
         chk({nm, "_latency"}, {31'd0, out_valid}, 32'd1);
         void'(sb.pop_front());
      end
   endtask

   // With out_ready high the result lasts exactly one cycle.
   task automatic after_vec(input string nm);
      @(negedge clk);
      chk({nm, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
      chk({nm, "_idle_busy"},  {31'd0, busy},      32'd0);
      chk({nm, "_idle_ready"}, {31'd0, in_ready},  32'd1);
   endtask

   task automatic beat(input logic [63:0] d);
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_res;
      tbl[0] = '{mk(1, 2, 3, 4, 5, 6, 7, 8),            16'h000F, 32'd36,        "basic"};
      tbl[1] = '{mk(-5, 3, -10, 2, 0, 0, 4, -1),        16'h000F, 32'hFFFF_FFF9, "signed"};
      tbl[2] = '{mk(32'h7FFF_FFFF, 1, 0, 0, 0, 0, 0, 0), 16'h000F, 32'h8000_0000, "wrap"};
      tbl[3] = '{mk(1, 2, 3, 4, 5, 6, 7, 8),            16'h0069, 32'd36,        "gaps"};
      tbl[4] = '{mk(100, -200, 300, -400, 500, -600, 700, -800), 16'h0155, 32'hFFFF_FE70, "alt"};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_reset("reset");
      rst = 1'b0;
      @(negedge clk);

      // Table-driven vectors with out_ready held high.
      for (int i = 0; i < 5; i++) begin
         run_vec(tbl[i].el, tbl[i].pat, tbl[i].exp, tbl[i].nm);
         after_vec(tbl[i].nm);
      end

      // Backpressure: result holds, offered beats are not consumed.
      out_ready = 1'b0;
      run_vec(tbl[0].el, 16'h000F, 32'd36, "bp");
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = {32'd9, 32'd9};
         @(negedge clk);
         chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_hold_data",  out_data,           32'd36);
         chk("bp_in_ready",   {31'd0, in_ready},  32'd0);
      end
      // Handshake with a beat offered in the same cycle: only the handshake.
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
      chk("bp_release_ready", {31'd0, in_ready},  32'd1);
      chk("bp_release_busy",  {31'd0, busy},      32'd0);
      in_valid = 1'b0;
      run_vec(tbl[0].el, 16'h000F, 32'd36, "bp_next");
      after_vec("bp_next");

      // Flush after two beats; the beat in the flush cycle is dropped.
      beat({32'd5, 32'd5});
      beat({32'd5, 32'd5});
      flush = 1'b1; in_valid = 1'b1; in_data = {32'd50, 32'd50};
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_busy",  {31'd0, busy},     32'd0);
      chk("flush_ready", {31'd0, in_ready}, 32'd1);
      run_vec(mk(1, 1, 1, 1, 1, 1, 1, 1), 16'h000F, 32'd8, "flush_next");
      after_vec("flush_next");

      // Flush in DONE drops the pending result without a handshake.
      out_ready = 1'b0;
      run_vec(tbl[1].el, 16'h000F, 32'hFFFF_FFF9, "flush_done");
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_done_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_done_busy",  {31'd0, busy},      32'd0);
      @(negedge clk);
      chk("flush_done_stays", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b1;

      // Reset after three beats.
      beat({32'd7, 32'd7});
      beat({32'd7, 32'd7});
      beat({32'd7, 32'd7});
      rst = 1'b1; in_valid = 1'b1; in_data = {32'd7, 32'd7};
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      check_reset("rst_mid");
      @(negedge clk);
      chk("rst_mid_no_result", {31'd0, out_valid}, 32'd0);
      run_vec(tbl[0].el, 16'h000F, 32'd36, "rst_next");
      after_vec("rst_next");

      // Single-beat build: back-to-back vectors, one result per two cycles.
      n_res = 0;
      for (int c = 1; c <= 8; c++) begin
         if (b_out_valid) begin
            n_res++;
            if (sb.size() > 0) chk("b1_sum", b_out_data, sb.pop_front());
            else chk("b1_unexpected", {31'd0, b_out_valid}, 32'd0);
         end
         b_in_valid = 1'b1;
         b_in_data  = {32'(c + 3), 32'(c + 2), 32'(c + 1), 32'(c)};
         if (b_in_ready) sb.push_back(32'(4 * c + 6));
         @(negedge clk);
      end
      b_in_valid = 1'b0;
      if (b_out_valid) begin
         n_res++;
         if (sb.size() > 0) chk("b1_sum", b_out_data, sb.pop_front());
         else chk("b1_unexpected", {31'd0, b_out_valid}, 32'd0);
      end
      chk("b1_results", 32'(n_res), 32'd4);
      chk("b1_sb_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/adder_acc_ctrl.md
# adder_acc_ctrl

Sequencing controller for the N-input adder tree (`adder`). It streams a LEN-element signed vector into one `adder` instance NUM elements per beat and accumulates the partial tree sums into a single WIDTH-bit total. It presents that total on a valid/ready output. It sits between the layer datapath (weighted products, delta terms) and the neuron sum/activation stage, so long fan-in sums can share one narrow adder tree.

## Interface
- `NUM`, default 2: elements per beat; equals the `NUM` of the internal `adder`.
- `WIDTH`, default 32: element, accumulator and result width (signed two's complement).
- `LEN`, default 8: elements per vector. Must be a multiple of `NUM`, with `LEN >= NUM`.
- `BEATS` (localparam) = `LEN/NUM`.
- `clk`  in  1: the only clock. All state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `flush`  in  1: synchronous abort. Discards the partial sum and any pending result.
- `in_valid`  in  1: `in_data` holds a valid beat.
- `in_ready`  out  1: the block accepts a beat this cycle.
- `in_data`  in  NUM*WIDTH: beat; element k is at `[k*WIDTH +: WIDTH]`.
- `out_valid`  out  1: `out_data` holds a completed vector sum.
- `out_ready`  in  1: downstream accepts the result.
- `out_data`  out  WIDTH: accumulated vector sum.
- `busy`  out  1: high while a vector is in progress or a result is pending (state ≠ IDLE).

## Operation
- Internal `adder #(NUM,WIDTH)` takes `in_data`. Its output `tsum` is combinational.
- Registers:
  - `state` ∈ {IDLE, ACC, DONE}
  - `acc[WIDTH-1:0]`
  - `cnt`, a beat counter of width clog2(BEATS)+1
- A beat is accepted when `in_valid && in_ready`.
- `in_ready` = 1 in IDLE and ACC, 0 in DONE.
- IDLE: on accept, `acc <= tsum` and `cnt <= 1`. Next state is DONE if BEATS==1, else ACC.
- ACC: on accept, `acc <= acc + tsum` and `cnt <= cnt+1`. When `cnt == BEATS-1` at accept, next state is DONE.
- ACC with no accept: all registers hold. Input gaps of any length are legal.
- DONE:
  - `out_valid` = 1 and `out_data` = `acc`, held stable until `out_valid && out_ready`.
  - On that handshake: go to IDLE and set `cnt <= 0`. `acc` holds.
- Arithmetic: all sums wrap modulo 2^WIDTH with no saturation or overflow flag. This matches `adder`.
- `flush`:
  - Any state goes to IDLE, with `cnt <= 0` and `acc <= 0`.
  - The beat presented in the flush cycle is dropped, even if `in_valid` is high.
  - A pending result is dropped without a handshake.
- Priority: `rst` > `flush` > normal operation.
- Simultaneous `out_ready` and `in_valid` in DONE: only the output handshake occurs. The next vector's first beat can be accepted the following cycle, in IDLE.

## Timing
- Reset values, applied the cycle after `rst` is sampled high:
  - `state` = IDLE, `acc` = 0, `cnt` = 0.
  - `out_valid` = 0, `out_data` = 0, `busy` = 0, `in_ready` = 1.
- Reset mid-vector or mid-DONE: identical to the above. No partial result appears afterwards.
- Latency: `out_valid` rises the cycle after the last (BEATS-th) beat is accepted.
- Maximum throughput: one vector per BEATS+1 cycles, with `out_ready` tied high.
- All outputs are registered or decoded from `state` only. There is no combinational path from `in_valid` or `out_ready` to any output.
- `in_data` path: one `adder` tree plus one WIDTH-bit add into `acc` per cycle.

## Test plan
All scenarios use NUM=2, WIDTH=32, LEN=8 (BEATS=4).
1. Basic sum: beats (1,2), (3,4), (5,6), (7,8) on consecutive cycles, `out_ready` = 1 → `out_valid` for exactly 1 cycle, one cycle after the 4th accept, with `out_data` = 36. Then `busy` = 0 and `in_ready` = 1.
2. Signed and wrap:
   - Beats (-5,3), (-10,2), (0,0), (4,-1) → `out_data` = -7 (0xFFFFFFF9).
   - Beats (0x7FFFFFFF,1), (0,0), (0,0), (0,0) → 0x80000000.
3. Input gaps: `in_valid` toggled 1,0,0,1,0,1,1 with the scenario 1 data → same result 36. `cnt` and `acc` hold during gaps.
4. Output backpressure: `out_ready` low for 5 cycles after the result.
   - `out_valid` and `out_data` (36) hold stable; `in_ready` = 0.
   - A beat offered while `in_ready` = 0 is not consumed.
   - `out_ready` = 1 → next cycle IDLE, `in_ready` = 1.
5. Flush and reset:
   - `flush` after 2 beats → IDLE, `acc` = 0. A following full vector (all beats (1,1)) → 8.
   - `flush` in DONE → `out_valid` drops with no handshake.
   - `rst` after 3 beats → all outputs at reset values. The next vector sums correctly.
6. BEATS==1 build (NUM=4, LEN=4): beat (1,2,3,4) → `out_valid` next cycle with `out_data` = 10. Back-to-back vectors sustain one result per 2 cycles.
